// File: rtl/total_alu.sv
// total_alu: 32-bit MIPS-style EX-stage ALU with HI/LO registers.
// Combinational logic/add/sub/slt/srl and an optional combinational unsigned
// divider, plus a sequential shift-add unsigned multiplier that writes HI/LO.
// Optional feature macro: ALU_DIVU_EN (defined -> DIVU divider present).
//
// Multiplier FSM
//   state  | meaning
//   S_IDLE | waiting for MULTU; DIVU may write HI/LO
//   S_BUSY | one shift-add iteration per edge, operands latched
//   S_DONE | product in HI/LO; waits for Signal to leave MULTU
module total_alu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] Output
);

  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(MUL_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } mul_state_t;

  mul_state_t         state_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic               div_we;

`ifdef ALU_DIVU_EN
  // Unsigned divider; divide-by-zero returns all-ones quotient, remainder = dividend
  always_comb begin
    quot = '1;
    rem  = dataA;
    if (dataB != '0) begin
      quot = dataA / dataB;
      rem  = dataA % dataB;
    end
  end

  // HI/LO take the divide result only when no multiply is in flight
  assign div_we = (Signal == F_DIVU) && (state_q != S_BUSY);
`else
  assign quot   = '0;
  assign rem    = '0;
  assign div_we = 1'b0;
`endif

  // Next accumulator value for one shift-add iteration
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
  end

  // Result mux; forced to zero while reset is held
  always_comb begin
    Output = '0;
    if (!reset) begin
      unique case (Signal)
        F_AND:   Output = dataA & dataB;
        F_OR:    Output = dataA | dataB;
        F_ADD:   Output = dataA + dataB;
        F_SUB:   Output = dataA - dataB;
        F_SLT:   Output = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
        F_SRL:   Output = dataA >> dataB[SH_W-1:0];
        F_DIVU:  Output = quot;
        F_MFHI:  Output = hi_q;
        F_MFLO:  Output = lo_q;
        default: Output = '0;
      endcase
    end
  end

  // Multiplier FSM and HI/LO write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (Signal == F_MULTU) begin
            mcand_q  <= {{WIDTH{1'b0}}, dataA};
            mplier_q <= dataB;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= S_BUSY;
          end else if (div_we) begin
            hi_q <= rem;
            lo_q <= quot;
          end
        end
        S_BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            hi_q    <= acc_d[2*WIDTH-1:WIDTH];
            lo_q    <= acc_d[WIDTH-1:0];
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (Signal != F_MULTU) state_q <= S_IDLE;
          if (div_we) begin
            hi_q <= rem;
            lo_q <= quot;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_total_alu.sv
// Testbench for total_alu: table of combinational vectors plus hand-written
// multiply/divide/reset sequences. Inputs change on the falling edge and
// outputs are sampled 1 ns later.
module tb_total_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [31:0] Output;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  total_alu #(.WIDTH(32), .MUL_CYCLES(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .dataA  (dataA),
    .dataB  (dataB),
    .Signal (Signal),
    .Output (Output)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  sig;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // Apply inputs on the falling edge, sample 1 ns later
  task automatic apply(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Signal = s;
    dataA  = a;
    dataB  = b;
    #1;
  endtask

  // Change only Signal within the current low phase and sample
  task automatic peek(input string name, input logic [5:0] s, input logic [31:0] expv);
    Signal = s;
    #1;
    chk(name, Output, expv);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    vecs[0]  = '{"and",       6'd36, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0};
    vecs[1]  = '{"or",        6'd37, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0};
    vecs[2]  = '{"add_wrap",  6'd32, 32'hFFFFFFFF, 32'd2,        32'd1};
    vecs[3]  = '{"sub_neg",   6'd34, 32'd5,        32'd7,        32'hFFFFFFFE};
    vecs[4]  = '{"slt_neg",   6'd42, 32'hFFFFFFFF, 32'd1,        32'd1};
    vecs[5]  = '{"slt_pos",   6'd42, 32'd1,        32'hFFFFFFFF, 32'd0};
    vecs[6]  = '{"slt_eq",    6'd42, 32'd7,        32'd7,        32'd0};
    vecs[7]  = '{"srl_31",    6'd2,  32'h80000000, 32'd31,       32'd1};
    vecs[8]  = '{"srl_36",    6'd2,  32'h12345678, 32'd36,       32'h01234567};
    vecs[9]  = '{"add_plain", 6'd32, 32'd1000,     32'd234,      32'd1234};
    vecs[10] = '{"bad_code",  6'd63, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    vecs[11] = '{"code_0",    6'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};

    reset  = 1'b1;
    Signal = 6'd32;
    dataA  = 32'd3;
    dataB  = 32'd4;
    edges(2);
    @(negedge clk); #1;
    chk("rst_add", Output, 32'd0);
    peek("rst_or", 6'd37, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    peek("rst_mfhi", 6'd16, 32'd0);
    peek("rst_mflo", 6'd18, 32'd0);

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].sig, vecs[i].a, vecs[i].b);
      chk(vecs[i].name, Output, vecs[i].exp);
    end

    // Divide write-back and divide-by-zero
    apply(6'd27, 32'd100, 32'd7);
`ifdef ALU_DIVU_EN
    chk("divu_q", Output, 32'd14);
    exp_lo = 32'd14;
    exp_hi = 32'd2;
`else
    chk("divu_off", Output, 32'd0);
`endif
    @(negedge clk);
    peek("divu_mflo", 6'd18, exp_lo);
    peek("divu_mfhi", 6'd16, exp_hi);
    apply(6'd27, 32'd9, 32'd0);
`ifdef ALU_DIVU_EN
    chk("divz_q", Output, 32'hFFFFFFFF);
    exp_lo = 32'hFFFFFFFF;
    exp_hi = 32'd9;
`else
    chk("divz_off", Output, 32'd0);
`endif
    @(negedge clk);
    peek("divz_mfhi", 6'd16, exp_hi);
    peek("divz_mflo", 6'd18, exp_lo);

    // Max-operand multiply, then hold MULTU with new operands: no restart
    apply(6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_out", Output, 32'd0);
    edges(35);
    @(negedge clk);
    dataA = 32'd3;
    dataB = 32'd5;
    edges(40);
    @(negedge clk);
    peek("mul1_mfhi", 6'd16, 32'hFFFFFFFE);
    peek("mul1_mflo", 6'd18, 32'h00000001);

    // Second multiply: old HI/LO visible mid-flight, operands latched,
    // DIVU ignored while busy, product lands exactly on edge 33
    apply(6'd25, 32'd123456, 32'd654321);
    edges(5);
    @(negedge clk);
    peek("busy_mfhi", 6'd16, 32'hFFFFFFFE);
    peek("busy_mflo", 6'd18, 32'h00000001);
    dataA  = 32'd100;
    dataB  = 32'd7;
    Signal = 6'd27;
    edges(1);
    @(negedge clk);
    peek("busy_divu_lo", 6'd18, 32'h00000001);
    peek("busy_divu_hi", 6'd16, 32'hFFFFFFFE);
    edges(26);
    @(negedge clk);
    peek("edge32_mflo", 6'd18, 32'h00000001);
    edges(1);
    @(negedge clk);
    peek("edge33_mflo", 6'd18, 32'd3470442048);
    peek("edge33_mfhi", 6'd16, 32'd18);

    // Reset during a multiply aborts it and clears HI/LO
    apply(6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF);
    edges(10);
    @(negedge clk);
    reset  = 1'b1;
    Signal = 6'd16;
    #1;
    chk("rst_mid_out", Output, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    peek("abort_mfhi", 6'd16, 32'd0);
    peek("abort_mflo", 6'd18, 32'd0);
    edges(40);
    @(negedge clk);
    peek("abort_late_hi", 6'd16, 32'd0);
    peek("abort_late_lo", 6'd18, 32'd0);

    // Small multiply after abort, Signal held
    apply(6'd25, 32'd6, 32'd7);
    edges(35);
    @(negedge clk);
    peek("mul3_mflo", 6'd18, 32'd42);
    peek("mul3_mfhi", 6'd16, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
